// File: rtl/mul_pkg.sv
// Shared types and defaults for the iterative fixed-point multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_FRAC_W = 13;
  localparam int unsigned DEF_STEP_W = 5;

  // Number of STEP_W-bit slices needed to cover a DATA_W-bit multiplier.
  function automatic int unsigned n_iter(input int unsigned data_w, input int unsigned step_w);
    return (data_w + step_w - 1) / step_w;
  endfunction

endpackage

// File: rtl/mul_partial.sv
// Unsigned DATA_W x STEP_W partial product, purely combinational.
module mul_partial
  import mul_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  logic [DATA_W-1:0]        mcand,
  input  logic [STEP_W-1:0]        mbits,
  output logic [DATA_W+STEP_W-1:0] prod_c
);

  localparam int unsigned P_W = DATA_W + STEP_W;

  assign prod_c = P_W'(mcand) * P_W'(mbits);

endmodule

// File: rtl/mul_fxp_iter.sv
// Iterative signed fixed-point multiplier, STEP_W multiplier bits per cycle,
// rounded and saturated result. Define MUL_FXP_ROUND_EN to round half away from zero.
module mul_fxp_iter
  import mul_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W,
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_VLD,
  output logic              O_RDY,
  input  logic [DATA_W-1:0] I_M1,
  input  logic [DATA_W-1:0] I_M2,
  output logic              O_VLD,
  input  logic              I_RDY,
  output logic [DATA_W-1:0] O_PRODUCT,
  output logic              O_OVF
);

  localparam int unsigned N_ITER = n_iter(DATA_W, STEP_W);
  localparam int unsigned CNT_W  = $clog2(N_ITER + 1);
  localparam int unsigned ACC_W  = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned PP_W   = DATA_W + STEP_W;

`ifdef MUL_FXP_ROUND_EN
  localparam logic [SUM_W-1:0] RND = SUM_W'(1) << (FRAC_W - 1);
`else
  localparam logic [SUM_W-1:0] RND = '0;
`endif
  localparam logic [SUM_W-1:0] NEG_LIM = SUM_W'(1) << (DATA_W - 1);
  localparam logic [SUM_W-1:0] POS_LIM = NEG_LIM - SUM_W'(1);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplr;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              neg;

  logic              last_c;
  logic [DATA_W-1:0] m1_mag_c;
  logic [DATA_W-1:0] m2_mag_c;
  logic [PP_W-1:0]   pp_c;
  logic [SUM_W-1:0]  mag_c;
  logic [DATA_W-1:0] res_c;
  logic              ovf_c;

  assign last_c   = (cnt == CNT_W'(N_ITER));
  assign m1_mag_c = I_M1[DATA_W-1] ? -I_M1 : I_M1;
  assign m2_mag_c = I_M2[DATA_W-1] ? -I_M2 : I_M2;

  mul_partial #(
    .DATA_W (DATA_W),
    .STEP_W (STEP_W)
  ) u_partial (
    .mcand  (mcand),
    .mbits  (mplr[STEP_W-1:0]),
    .prod_c (pp_c)
  );

  // State register
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (I_VLD)          state_next = CALC;
      CALC:    if (last_c)         state_next = DONE;
      DONE:    if (O_VLD && I_RDY) state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // Handshake flags follow the state being entered
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      O_VLD <= 1'b0;
      O_RDY <= 1'b1;
    end else begin
      O_VLD <= (state_next == DONE);
      O_RDY <= (state_next == IDLE);
    end
  end

  // Round the magnitude, reapply the sign, saturate to DATA_W
  always_comb begin
    mag_c = (SUM_W'(acc) + RND) >> FRAC_W;
    res_c = '0;
    ovf_c = 1'b0;
    if (mag_c != '0) begin
      if (!neg) begin
        if (mag_c > POS_LIM) begin
          res_c = {1'b0, {(DATA_W-1){1'b1}}};
          ovf_c = 1'b1;
        end else begin
          res_c = DATA_W'(mag_c);
        end
      end else begin
        if (mag_c > NEG_LIM) begin
          res_c = {1'b1, {(DATA_W-1){1'b0}}};
          ovf_c = 1'b1;
        end else begin
          res_c = -DATA_W'(mag_c);
        end
      end
    end
  end

  // Operand capture, shift-add iterations and result register
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      O_PRODUCT <= '0;
      O_OVF     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (I_VLD) begin
            mcand <= m1_mag_c;
            mplr  <= m2_mag_c;
            neg   <= I_M1[DATA_W-1] ^ I_M2[DATA_W-1];
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          if (last_c) begin
            O_PRODUCT <= res_c;
            O_OVF     <= ovf_c;
          end else begin
            acc  <= acc + (ACC_W'(pp_c) << (STEP_W * 32'(cnt)));
            mplr <= mplr >> STEP_W;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_fxp_iter.sv
// Bench for mul_fxp_iter: directed corner cases plus randomized traffic against
// an arithmetic reference model. Honours MUL_FXP_ROUND_EN like the design.
module tb_mul_fxp_iter;

  localparam int unsigned NI = 4;

`ifdef MUL_FXP_ROUND_EN
  localparam longint RND = 4096;
  localparam logic [16:0] EXP_TINY_POS = 17'h00001;
  localparam logic [16:0] EXP_TINY_NEG = 17'h0FFFF;
`else
  localparam longint RND = 0;
  localparam logic [16:0] EXP_TINY_POS = 17'h00000;
  localparam logic [16:0] EXP_TINY_NEG = 17'h00000;
`endif

  logic        I_CLK = 1'b0;
  logic        I_RST = 1'b1;
  logic        I_VLD = 1'b0;
  logic        I_RDY = 1'b1;
  logic [15:0] I_M1  = '0;
  logic [15:0] I_M2  = '0;
  logic        O_RDY;
  logic        O_VLD;
  logic        O_OVF;
  logic [15:0] O_PRODUCT;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 I_CLK = ~I_CLK;

  mul_fxp_iter dut (
    .I_CLK     (I_CLK),
    .I_RST     (I_RST),
    .I_VLD     (I_VLD),
    .O_RDY     (O_RDY),
    .I_M1      (I_M1),
    .I_M2      (I_M2),
    .O_VLD     (O_VLD),
    .I_RDY     (I_RDY),
    .O_PRODUCT (O_PRODUCT),
    .O_OVF     (O_OVF)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact product, round/truncate the magnitude, sign, clamp. Returns {ovf, product}.
  function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint mag;
    p   = longint'($signed(a)) * longint'($signed(b));
    mag = (p < 0) ? -p : p;
    mag = (mag + RND) >> 13;
    if (mag == 0) return 17'h00000;
    if (p > 0) return (mag > 32767) ? {1'b1, 16'h7FFF} : {1'b0, 16'(mag)};
    return (mag > 32768) ? {1'b1, 16'h8000} : {1'b0, 16'(-mag)};
  endfunction

  // Cycle-level expectation: idle / busy for NI+1 cycles / holding result until taken
  int          ph    = 0;
  int          ticks = 0;
  logic        m_rdy = 1'b1;
  logic        m_vld = 1'b0;
  logic [16:0] m_res = '0;
  logic [16:0] pend  = '0;

  always @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      ph = 0; ticks = 0; m_rdy = 1'b1; m_vld = 1'b0; m_res = '0;
    end else begin
      case (ph)
        0: if (I_VLD) begin
          pend = ref_mul(I_M1, I_M2); ph = 1; ticks = 0; m_rdy = 1'b0;
        end
        1: begin
          ticks++;
          if (ticks == NI + 1) begin m_vld = 1'b1; m_res = pend; ph = 2; end
        end
        default: if (I_RDY) begin m_vld = 1'b0; m_rdy = 1'b1; ph = 0; end
      endcase
    end
  end

  always @(negedge I_CLK) begin
    if (chk_en) begin
      chk("cyc_rdy", 32'(O_RDY), 32'(m_rdy));
      chk("cyc_vld", 32'(O_VLD), 32'(m_vld));
      chk("cyc_result", 32'({O_OVF, O_PRODUCT}), 32'(m_res));
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp, input string name);
    int lat;
    @(posedge I_CLK); #1;
    I_M1 = a; I_M2 = b; I_VLD = 1'b1;
    @(posedge I_CLK); #1;
    I_VLD = 1'b0;
    lat = 0;
    while (!O_VLD && lat < 20) begin
      @(posedge I_CLK); #1;
      lat++;
    end
    chk({name, "_lat"}, 32'(lat), 32'd5);
    chk(name, 32'({O_OVF, O_PRODUCT}), 32'(exp));
    @(posedge I_CLK); #1;
    chk({name, "_vld_drop"}, 32'(O_VLD), 32'd0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge I_CLK);
    #1 I_RST = 1'b0;
    @(negedge I_CLK);
    chk("reset_vld", 32'(O_VLD), 32'd0);
    chk("reset_rdy", 32'(O_RDY), 32'd1);
    chk("reset_prod", 32'(O_PRODUCT), 32'd0);
    chk("reset_ovf", 32'(O_OVF), 32'd0);
    chk_en = 1'b1;

    chk("model_one", 32'(ref_mul(16'h2000, 16'h2000)), 32'h02000);
    chk("model_neg", 32'(ref_mul(16'hE000, 16'h3000)), 32'h0D000);
    chk("model_satp", 32'(ref_mul(16'h8000, 16'h8000)), 32'h17FFF);
    chk("model_satn", 32'(ref_mul(16'h6000, 16'hA000)), 32'h18000);
    chk("model_tiny", 32'(ref_mul(16'hFFFF, 16'h1000)), 32'(EXP_TINY_NEG));

    do_op(16'h2000, 16'h2000, 17'h02000, "one_x_one");
    do_op(16'hE000, 16'h3000, 17'h0D000, "neg_x_pos");
    do_op(16'h8000, 16'h8000, 17'h17FFF, "sat_pos");
    do_op(16'h6000, 16'hA000, 17'h18000, "sat_neg");
    do_op(16'h0001, 16'h1000, EXP_TINY_POS, "tiny_pos");
    do_op(16'hFFFF, 16'h1000, EXP_TINY_NEG, "tiny_neg");
    do_op(16'h0000, 16'h8000, 17'h00000, "zero");

    // Back-pressure: result must hold, new operands ignored
    begin
      int lat;
      I_RDY = 1'b0;
      @(posedge I_CLK); #1;
      I_M1 = 16'h3000; I_M2 = 16'h2000; I_VLD = 1'b1;
      @(posedge I_CLK); #1;
      I_VLD = 1'b0;
      lat = 0;
      while (!O_VLD && lat < 20) begin
        @(posedge I_CLK); #1;
        lat++;
      end
      chk("stall_lat", 32'(lat), 32'd5);
      for (int i = 0; i < 3; i++) begin
        I_VLD = 1'b1; I_M1 = 16'($urandom); I_M2 = 16'($urandom);
        @(posedge I_CLK); #1;
        chk("stall_vld", 32'(O_VLD), 32'd1);
        chk("stall_rdy", 32'(O_RDY), 32'd0);
        chk("stall_res", 32'({O_OVF, O_PRODUCT}), 32'h03000);
      end
      I_VLD = 1'b0; I_RDY = 1'b1;
      @(posedge I_CLK); #1;
      chk("release_vld", 32'(O_VLD), 32'd0);
      chk("release_rdy", 32'(O_RDY), 32'd1);
      chk("retain_res", 32'({O_OVF, O_PRODUCT}), 32'h03000);
    end

    // Reset during the second CALC cycle aborts the operation
    @(posedge I_CLK); #1;
    I_M1 = 16'h7000; I_M2 = 16'h7000; I_VLD = 1'b1;
    @(posedge I_CLK); #1;
    I_VLD = 1'b0;
    @(posedge I_CLK); #1;
    I_RST = 1'b1;
    @(posedge I_CLK); #1;
    I_RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge I_CLK); #1;
      chk("abort_novld", 32'(O_VLD), 32'd0);
    end
    chk("abort_cleared", 32'({O_OVF, O_PRODUCT}), 32'h00000);
    do_op(16'h4000, 16'h2000, 17'h04000, "after_abort");

    // Random traffic with random back-pressure; the cycle checker does the work
    repeat (3000) begin
      @(posedge I_CLK); #1;
      I_VLD = ($urandom_range(0, 2) == 0);
      I_M1  = pick();
      I_M2  = pick();
      I_RDY = ($urandom_range(0, 3) != 0);
    end
    I_VLD = 1'b0;
    I_RDY = 1'b1;
    repeat (20) @(posedge I_CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
